bram_row_drain: RTL
===================

# bram_row_drain

Drains rows of on-chip BRAM back out to external memory, the outbound counterpart of the inbound fill and row-buffer read address path. On `start` it reads `num_rows` wide words from BRAM port B, beginning at `ADDR_B = 0`. Each wide word is serialized into `` `ROW_RATIO`` (4) narrow words, and each narrow word is written to external memory at consecutive addresses from `base_addr`, under a valid/ready handshake. It sits between the BRAM port B and the external memory write port, and is started by the top-level controller once processing of a BRAM image is complete.

## Interface
Parameters:
- `DATA_W`, `` `DATA_WIDTH``: narrow (external memory) word width.
- `ADDR_W`, `` `ADDR_WIDTH``: BRAM port A address width. Port B is `ADDR_W-2` bits wide.
- `MEM_AW`, `` $clog2(`MEM_SIZE) ``: external memory address width.

Ports:
- `CLK`, input, 1: single clock. All logic is on its rising edge.
- `rst`, input, 1: reset. Synchronous, active-low.
- `start`, input, 1: begin a drain. Sampled only in IDLE.
- `base_addr`, input, `MEM_AW`: first external address. Latched on an accepted `start`.
- `num_rows`, input, `ADDR_W-1`: number of wide words to drain, range 0..2^(ADDR_W-2). Latched on an accepted `start`.
- `bram_en`, output, 1: port B read enable.
- `ADDR_B`, output, `ADDR_W-2`: port B row address.
- `DOUT_B`, input, `4*DATA_W`: port B read data. Latency is 1 cycle.
- `mem_we`, output, 1: write valid.
- `mem_ready`, input, 1: memory accepts the write this cycle.
- `mem_address`, output, `MEM_AW`: write address.
- `mem_wdata`, output, `DATA_W`: write data.
- `busy`, output, 1: high in READ, WAIT and SEND.
- `done`, output, 1: one-cycle completion pulse.

## Operation
States:
- IDLE:
  - `start` with `num_rows` ≠ 0 → READ.
  - `start` with `num_rows` = 0 → DONE.
  - Latches `base_addr` into `mem_address` and `num_rows` into the row counter. Clears `ADDR_B` to 0.
- READ: `bram_en` = 1 with the current `ADDR_B`. → WAIT unconditionally.
- WAIT: `DOUT_B` is valid in this cycle and is captured into the lane shift register. Lane counter is set to 0. → SEND.
- SEND:
  - `mem_we` = 1 and `mem_wdata` = current lane. Lane 0 = `DOUT_B[DATA_W-1:0]`, sent first; lane 3 = MSBs.
  - On `mem_we && mem_ready`: shift to the next lane and increment `mem_address`.
  - After the lane-3 handshake, `ADDR_B` increments and the row counter decrements. Then → READ if rows remain, else → DONE.
- DONE: `done` = 1 for this one cycle. → IDLE.

Handshake rules:
- While `mem_we` = 1 and `mem_ready` = 0, `mem_we`, `mem_address` and `mem_wdata` are held stable.
- `mem_we` never drops without a handshake.

Wrap and ignore rules:
- `mem_address` increments modulo `` `MEM_SIZE``: `MEM_SIZE-1` → 0.
- `ADDR_B` increments modulo 2^(ADDR_W-2).
- `start` outside IDLE is ignored.

## Timing
- Reset (`rst` = 0 at an edge): state = IDLE. `bram_en`, `ADDR_B`, `mem_we`, `mem_address`, `mem_wdata`, `busy` and `done` all = 0. The lane register is cleared.
- Reset mid-drain aborts at the next edge: no further writes and no `done`.
- Start latency: `start` sampled at edge 0 → READ during cycle 1, WAIT during cycle 2, first `mem_we` during cycle 3.
- Throughput with `mem_ready` tied high: 6 cycles per wide word (READ, WAIT, 4×SEND). Total for N rows = 6N + 1 (DONE) cycles after the accepting edge.
- The `done` cycle is the cycle after the final handshake. `busy` is 0 during the `done` cycle.

## Structure
- `package_fpga.v` gains `` `DATA_WIDTH`` and `` `ROW_RATIO`` (= 4). It reuses the existing `` `ADDR_WIDTH`` and `` `MEM_SIZE``.
- State encoding is a set of localparams inside the module (5 states, 3-bit).
- Sub-module `row_serializer`:
  - Contains the 4-lane shift register and the 2-bit lane counter.
  - Inputs: `load`, `advance`, a wide data input.
  - Outputs: the current lane and a `last` flag.
- The top module holds the FSM, the `ADDR_B`/`mem_address` counters and the row counter.

## Test plan
- **Single row:** `num_rows` = 1, `base_addr` = 0x010, `DOUT_B` = {0xD,0xC,0xB,0xA} (DATA_W = 4), `mem_ready` = 1.
  - Writes 0xA@0x010, 0xB@0x011, 0xC@0x012, 0xD@0x013 in cycles 3–6.
  - `done` in cycle 7.
- **Back-pressure:** `mem_ready` low for 3 cycles on lane 2 → `mem_we`, address and data held stable throughout. No duplicate or skipped write.
- **Multi-row and address wrap:**
  - `num_rows` = 3, `base_addr` = `MEM_SIZE`-2 → 12 writes at addresses `MEM_SIZE`-2, `MEM_SIZE`-1, 0..9.
  - `ADDR_B` sequence 0, 1, 2.
  - 19 cycles from `start` to `done`.
- **Zero rows:** `num_rows` = 0 → no `bram_en`, no `mem_we`. `done` one cycle after `start`.
- **Start while busy:** second `start` during SEND is ignored, so `base_addr`/`num_rows` changes have no effect.
- **Reset mid-drain:** `rst` = 0 after the 5th write → all outputs 0 on the next edge. A fresh `start` then behaves exactly as the single-row case.

Source files
------------

// File: rtl/bram_row_drain_pkg.sv
// Shared widths, memory geometry and FSM encoding for the BRAM row drain path.
package bram_row_drain_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int ROW_RATIO  = 4;
  localparam int ADDR_WIDTH = 6;
  localparam int MEM_SIZE   = 1000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } drain_state_e;

endpackage

// File: rtl/row_serializer.sv
// Splits one wide BRAM row into narrow lanes, lane 0 (LSBs) first; 1-cycle load latency.
// Holds the current lane indefinitely until advance, so downstream stalls simply freeze it.
module row_serializer #(
  parameter int DATA_W = 4,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    advance,
  input  logic [LANES*DATA_W-1:0] row_dat,
  output logic [DATA_W-1:0]       lane_dat,
  output logic                    last
);

  localparam int CNT_W = $clog2(LANES);

  logic [LANES*DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]        lane_cnt;

  // Zeros shift in from the top so the output idles at 0 after a row drains.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q  <= '0;
      lane_cnt <= '0;
    end else if (load) begin
      shift_q  <= row_dat;
      lane_cnt <= '0;
    end else if (advance) begin
      shift_q  <= {{DATA_W{1'b0}}, shift_q[LANES*DATA_W-1:DATA_W]};
      lane_cnt <= lane_cnt + 1'b1;
    end
  end

  assign lane_dat = shift_q[DATA_W-1:0];
  assign last     = (lane_cnt == CNT_W'(LANES - 1));

endmodule

// File: rtl/bram_row_drain.sv
// Drains num_rows BRAM rows to external memory as narrow words; 6 cycles/row, done after last write.
// mem_we/mem_address/mem_wdata hold steady while mem_ready is low; start is ignored unless idle.
module bram_row_drain
  import bram_row_drain_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int MEM_AW = $clog2(MEM_SIZE)
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic                          start,
  input  logic [MEM_AW-1:0]             base_addr,
  input  logic [ADDR_W-2:0]             num_rows,
  output logic                          bram_en,
  output logic [ADDR_W-3:0]             ADDR_B,
  input  logic [ROW_RATIO*DATA_W-1:0]   DOUT_B,
  output logic                          mem_we,
  input  logic                          mem_ready,
  output logic [MEM_AW-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          busy,
  output logic                          done
);

  drain_state_e state_q, state_d;

  logic [ADDR_W-3:0] addr_b_q;
  logic [ADDR_W-2:0] row_cnt;
  logic              accept;
  logic              load;
  logic              advance;
  logic              row_step;
  logic              last_lane;
  logic [MEM_AW-1:0] mem_addr_nxt;

  always_ff @(posedge CLK) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bram_en  = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    row_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (num_rows == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        bram_en = 1'b1;
        busy    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // BRAM data for the row issued in READ is on DOUT_B now.
        busy    = 1'b1;
        load    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (mem_ready) begin
          advance = 1'b1;
          if (last_lane) begin
            row_step = 1'b1;
            state_d  = (row_cnt == (ADDR_W-1)'(1)) ? S_DONE : S_READ;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // External memory may not be a power of two, so wrap explicitly.
  assign mem_addr_nxt = (mem_address == MEM_AW'(MEM_SIZE - 1)) ? '0
                                                               : mem_address + MEM_AW'(1);

  always_ff @(posedge CLK) begin
    if (!rst) begin
      addr_b_q    <= '0;
      row_cnt     <= '0;
      mem_address <= '0;
    end else begin
      if (accept) begin
        addr_b_q    <= '0;
        row_cnt     <= num_rows;
        mem_address <= base_addr;
      end
      if (advance) mem_address <= mem_addr_nxt;
      if (row_step) begin
        addr_b_q <= addr_b_q + 1'b1;
        row_cnt  <= row_cnt - 1'b1;
      end
    end
  end

  assign ADDR_B = addr_b_q;

  row_serializer #(
    .DATA_W (DATA_W),
    .LANES  (ROW_RATIO)
  ) u_row_serializer (
    .clk      (CLK),
    .rst      (rst),
    .load     (load),
    .advance  (advance),
    .row_dat  (DOUT_B),
    .lane_dat (mem_wdata),
    .last     (last_lane)
  );

endmodule
